// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Shares the core's single memory port between instruction fetch and the
// load/store unit. The winning request is registered onto the bus and held
// there until the bus answers with bus_ready. The response is then routed back
// to whichever requester owns the transaction. A watchdog aborts any
// transaction that waits TIMEOUT cycles without an answer.
//
// Optional feature:
//   ARB_RR_EN  - when defined, contention is resolved round-robin with a
//                one-bit last_grant register. When undefined, data always wins
//                contention, so sustained data traffic can starve fetch.
//
// Parameters:
//   ADDR_W   - address width
//   XLEN     - data width
//   TIMEOUT  - number of bus wait cycles before an abort (1..65535)
//
// Ports:
//   clk, rst                  - clock and asynchronous active-high reset
//   i_req, i_addr             - fetch request and address
//   i_rdata, i_ready          - fetch read data and one-cycle completion pulse
//   d_req, d_we, d_addr,
//   d_wdata, d_wstrb          - data request, store flag, address, store data
//                               and byte enables
//   d_rdata, d_ready          - load data and one-cycle completion pulse
//   bus_req, bus_we, bus_addr,
//   bus_wdata, bus_wstrb      - registered bus request and its fields
//   bus_rdata, bus_ready      - bus read data and one-cycle completion pulse
//   bus_err                   - one-cycle pulse when the watchdog aborts
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [XLEN-1:0]   i_rdata,
   output logic              i_ready,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [XLEN-1:0]   d_wdata,
   input  logic [3:0]        d_wstrb,
   output logic [XLEN-1:0]   d_rdata,
   output logic              d_ready,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [XLEN-1:0]   bus_wdata,
   output logic [3:0]        bus_wstrb,
   input  logic [XLEN-1:0]   bus_rdata,
   input  logic              bus_ready,
   output logic              bus_err
);

   typedef enum logic [1:0] {
      IDLE,
      I_BUSY,
      D_BUSY
   } state_t;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t      state;
   logic [15:0] wait_cnt;
   logic        grant_data;
   logic        timeout_hit;
   logic        txn_end;

`ifdef ARB_RR_EN
   // Set when the most recent grant went to data; reset means fetch was
   // granted last, so data is favoured on the first contention.
   logic        last_grant;

   // On contention the requester that was not granted last wins.
   always_comb begin
      grant_data = d_req && (!i_req || !last_grant);
   end
`else
   // Fixed priority: data wins whenever it is requesting.
   always_comb begin
      grant_data = d_req;
   end
`endif

   // The watchdog fires in the BUSY cycle where the count reaches TIMEOUT-1
   // and the bus still has not answered. Either outcome ends the transaction.
   always_comb begin
      timeout_hit = (state != IDLE) && !bus_ready && (wait_cnt == TMO_LAST);
      txn_end     = (state != IDLE) && (bus_ready || timeout_hit);
      bus_err     = timeout_hit;
   end

   // Completion is reported to the owner in the same cycle the bus answers.
   // An owner that has already dropped its request gets no ready pulse. Read
   // data is only passed through on a real bus answer; an abort returns zero.
   always_comb begin
      i_ready = (state == I_BUSY) && i_req && txn_end;
      d_ready = (state == D_BUSY) && d_req && txn_end;
      i_rdata = (i_ready && bus_ready) ? bus_rdata : '0;
      d_rdata = (d_ready && bus_ready) ? bus_rdata : '0;
   end

   // Main controller: grants from IDLE, latches the winner's fields onto the
   // bus, holds them through BUSY and returns to IDLE on completion or abort.
   // bus_ready arriving while IDLE is simply ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_wstrb <= '0;
`ifdef ARB_RR_EN
         last_grant <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (i_req || d_req) begin
                  bus_req  <= 1'b1;
                  wait_cnt <= '0;
`ifdef ARB_RR_EN
                  last_grant <= grant_data;
`endif
                  if (grant_data) begin
                     state     <= D_BUSY;
                     bus_we    <= d_we;
                     bus_addr  <= d_addr;
                     bus_wdata <= d_wdata;
                     bus_wstrb <= d_wstrb;
                  end else begin
                     state     <= I_BUSY;
                     bus_we    <= 1'b0;
                     bus_addr  <= i_addr;
                     bus_wdata <= '0;
                     bus_wstrb <= 4'h0;
                  end
               end
            end
            I_BUSY, D_BUSY: begin
               if (txn_end) begin
                  state   <= IDLE;
                  bus_req <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            default: begin
               state   <= IDLE;
               bus_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. A transaction-level reference model
// tracks the single outstanding bus transaction (owner, latched fields and
// number of cycles already waited) and predicts every output each cycle.
// Directed sequences cover the test plan scenarios, followed by a long run of
// randomized requesters and a randomized bus responder.
//
// Ports of the DUT are all driven/observed here; TIMEOUT is set to 4 so the
// watchdog is exercised frequently.
module tb_mem_arbiter;

   localparam int ADDR_W     = 32;
   localparam int XLEN       = 32;
   localparam int TB_TIMEOUT = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              i_req = 1'b0;
   logic [ADDR_W-1:0] i_addr = '0;
   logic [XLEN-1:0]   i_rdata;
   logic              i_ready;
   logic              d_req = 1'b0;
   logic              d_we = 1'b0;
   logic [ADDR_W-1:0] d_addr = '0;
   logic [XLEN-1:0]   d_wdata = '0;
   logic [3:0]        d_wstrb = '0;
   logic [XLEN-1:0]   d_rdata;
   logic              d_ready;
   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [XLEN-1:0]   bus_wdata;
   logic [3:0]        bus_wstrb;
   logic [XLEN-1:0]   bus_rdata = '0;
   logic              bus_ready = 1'b0;
   logic              bus_err;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: one outstanding transaction at most.
   bit                m_busy;
   bit                m_data;
   bit                m_last_data;
   logic [ADDR_W-1:0] m_addr;
   logic              m_we;
   logic [XLEN-1:0]   m_wdata;
   logic [3:0]        m_wstrb;
   int                m_waited;

   // Model predictions from the most recent comparison, used by the random
   // requesters to know when their request has been served.
   bit                prev_i_ready;
   bit                prev_d_ready;

   mem_arbiter #(
      .ADDR_W (ADDR_W),
      .XLEN   (XLEN),
      .TIMEOUT(TB_TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .i_req    (i_req),
      .i_addr   (i_addr),
      .i_rdata  (i_rdata),
      .i_ready  (i_ready),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_wstrb  (d_wstrb),
      .d_rdata  (d_rdata),
      .d_ready  (d_ready),
      .bus_req  (bus_req),
      .bus_we   (bus_we),
      .bus_addr (bus_addr),
      .bus_wdata(bus_wdata),
      .bus_wstrb(bus_wstrb),
      .bus_rdata(bus_rdata),
      .bus_ready(bus_ready),
      .bus_err  (bus_err)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s at %0t: observed 0x%0h expected 0x%0h",
                  tag, $time, observed, expected);
      end
   endtask

   function automatic void modelReset();
      m_busy      = 1'b0;
      m_data      = 1'b0;
      m_last_data = 1'b0;
      m_addr      = '0;
      m_we        = 1'b0;
      m_wdata     = '0;
      m_wstrb     = '0;
      m_waited    = 0;
   endfunction

   // Advance the model across one rising edge using the inputs the DUT
   // sampled at that edge.
   function automatic void modelStep();
      bit pick_data;
      if (rst) begin
         modelReset();
      end else if (m_busy) begin
         if (bus_ready || m_waited == TB_TIMEOUT - 1)
            m_busy = 1'b0;
         else
            m_waited++;
      end else if (i_req || d_req) begin
`ifdef ARB_RR_EN
         pick_data = d_req && (!i_req || !m_last_data);
`else
         pick_data = d_req;
`endif
         m_busy      = 1'b1;
         m_waited    = 0;
         m_data      = pick_data;
         m_last_data = pick_data;
         m_addr      = pick_data ? d_addr : i_addr;
         m_we        = pick_data ? d_we : 1'b0;
         m_wdata     = pick_data ? d_wdata : '0;
         m_wstrb     = pick_data ? d_wstrb : 4'h0;
      end
   endfunction

   // One clock: update the model at the edge, then leave 1 ns for the DUT.
   task automatic tick();
      @(posedge clk);
      modelStep();
      #1;
   endtask

   // Compare every output with the model's prediction for the current
   // cycle, given the inputs now applied.
   task automatic compareAll();
      bit done, tmo, e_i_ready, e_d_ready;
      logic [XLEN-1:0] e_i_rdata, e_d_rdata;
      #1;
      done      = m_busy && bus_ready;
      tmo       = m_busy && !bus_ready && (m_waited == TB_TIMEOUT - 1);
      e_i_ready = m_busy && !m_data && i_req && (done || tmo);
      e_d_ready = m_busy && m_data && d_req && (done || tmo);
      e_i_rdata = (e_i_ready && done) ? bus_rdata : '0;
      e_d_rdata = (e_d_ready && done) ? bus_rdata : '0;
      checkOutput("bus_req", 32'(bus_req), 32'(m_busy));
      checkOutput("bus_err", 32'(bus_err), 32'(tmo));
      checkOutput("i_ready", 32'(i_ready), 32'(e_i_ready));
      checkOutput("d_ready", 32'(d_ready), 32'(e_d_ready));
      checkOutput("i_rdata", i_rdata, e_i_rdata);
      checkOutput("d_rdata", d_rdata, e_d_rdata);
      if (m_busy) begin
         checkOutput("bus_addr", bus_addr, m_addr);
         checkOutput("bus_we", 32'(bus_we), 32'(m_we));
         checkOutput("bus_wstrb", 32'(bus_wstrb), 32'(m_wstrb));
         if (m_data)
            checkOutput("bus_wdata", bus_wdata, m_wdata);
      end
      prev_i_ready = e_i_ready;
      prev_d_ready = e_d_ready;
   endtask

   // Randomized requesters that respect the hold-until-ready protocol, with
   // an occasional early drop, plus a random bus responder.
   task automatic applyStimulus();
      if (!i_req || prev_i_ready) begin
         i_req = (m_busy && !m_data && !prev_i_ready) ? 1'b0
                                                      : 1'($urandom_range(0, 1));
         if (i_req)
            i_addr = $urandom;
      end else if ($urandom_range(0, 29) == 0) begin
         i_req = 1'b0;
      end
      if (!d_req || prev_d_ready) begin
         d_req = (m_busy && m_data && !prev_d_ready) ? 1'b0
                                                     : 1'($urandom_range(0, 1));
         if (d_req) begin
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_wstrb = 4'($urandom_range(0, 15));
         end
      end else if ($urandom_range(0, 29) == 0) begin
         d_req = 1'b0;
      end
      bus_ready = ($urandom_range(0, 2) == 0);
      bus_rdata = $urandom;
   endtask

   initial begin
      modelReset();
      prev_i_ready = 1'b0;
      prev_d_ready = 1'b0;

      // Reset values, applied asynchronously.
      #1 rst = 1'b1;
      #1;
      checkOutput("rst_bus_req", 32'(bus_req), 32'd0);
      checkOutput("rst_bus_we", 32'(bus_we), 32'd0);
      checkOutput("rst_bus_err", 32'(bus_err), 32'd0);
      checkOutput("rst_bus_addr", bus_addr, 32'd0);
      checkOutput("rst_bus_wdata", bus_wdata, 32'd0);
      checkOutput("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
      checkOutput("rst_i_ready", 32'(i_ready), 32'd0);
      checkOutput("rst_d_ready", 32'(d_ready), 32'd0);
      tick();
      rst = 1'b0;
      compareAll();

      // Single fetch answered in the first BUSY cycle.
      i_req  = 1'b1;
      i_addr = 32'h100;
      compareAll();
      tick();
      bus_ready = 1'b1;
      bus_rdata = 32'h0000_0013;
      compareAll();
      checkOutput("fetch_bus_req", 32'(bus_req), 32'd1);
      checkOutput("fetch_bus_addr", bus_addr, 32'h100);
      checkOutput("fetch_bus_we", 32'(bus_we), 32'd0);
      checkOutput("fetch_i_ready", 32'(i_ready), 32'd1);
      checkOutput("fetch_i_rdata", i_rdata, 32'h13);
      tick();
      i_req     = 1'b0;
      bus_ready = 1'b0;
      compareAll();

      // Store answered after three BUSY cycles; fields stay stable.
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h2000;
      d_wdata = 32'hDEAD_BEEF;
      d_wstrb = 4'hF;
      compareAll();
      for (int k = 1; k <= 3; k++) begin
         tick();
         bus_ready = (k == 3);
         bus_rdata = 32'h1234_5678;
         compareAll();
         checkOutput("store_addr", bus_addr, 32'h2000);
         checkOutput("store_wdata", bus_wdata, 32'hDEAD_BEEF);
         checkOutput("store_wstrb", 32'(bus_wstrb), 32'hF);
         checkOutput("store_we", 32'(bus_we), 32'd1);
         checkOutput("store_d_ready", 32'(d_ready), 32'(k == 3));
         checkOutput("store_i_ready", 32'(i_ready), 32'd0);
      end
      tick();
      d_req     = 1'b0;
      bus_ready = 1'b0;
      compareAll();

      // Contention from a fresh reset so the round-robin pointer starts
      // with data favoured.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      compareAll();
      i_req   = 1'b1;
      i_addr  = 32'h400;
      d_req   = 1'b1;
      d_we    = 1'b0;
      d_addr  = 32'h3000;
      d_wdata = 32'h0;
      d_wstrb = 4'h0;
      compareAll();
      for (int j = 0; j < 4; j++) begin
         tick();
         bus_ready = 1'b1;
         bus_rdata = 32'hA000_0000 + 32'(j);
         compareAll();
`ifdef ARB_RR_EN
         checkOutput("contend_addr", bus_addr, (j % 2 == 0) ? 32'h3000 : 32'h400);
`else
         checkOutput("contend_addr", bus_addr, 32'h3000);
         checkOutput("contend_i_ready", 32'(i_ready), 32'd0);
`endif
         tick();
         bus_ready = 1'b0;
         compareAll();
         checkOutput("contend_bubble", 32'(bus_req), 32'd0);
      end
      // Both requesters drop while the next transaction is in flight.
      tick();
      i_req     = 1'b0;
      d_req     = 1'b0;
      bus_ready = 1'b1;
      compareAll();
      checkOutput("contend_drop_d", 32'(d_ready), 32'd0);
      tick();
      bus_ready = 1'b0;
      compareAll();

      // Watchdog abort: bus never answers.
      d_req   = 1'b1;
      d_we    = 1'b0;
      d_addr  = 32'h5000;
      compareAll();
      for (int k = 1; k <= TB_TIMEOUT; k++) begin
         tick();
         bus_ready = 1'b0;
         bus_rdata = 32'hFFFF_FFFF;
         compareAll();
         checkOutput("tmo_bus_err", 32'(bus_err), 32'(k == TB_TIMEOUT));
         checkOutput("tmo_d_ready", 32'(d_ready), 32'(k == TB_TIMEOUT));
         checkOutput("tmo_d_rdata", d_rdata, 32'd0);
      end
      tick();
      d_req = 1'b0;
      compareAll();
      checkOutput("tmo_after_req", 32'(bus_req), 32'd0);

      // Reset in the second BUSY cycle of a fetch.
      i_req  = 1'b1;
      i_addr = 32'h600;
      compareAll();
      tick();
      compareAll();
      tick();
      compareAll();
      bus_ready = 1'b1;
      rst       = 1'b1;
      #1;
      checkOutput("midrst_bus_req", 32'(bus_req), 32'd0);
      checkOutput("midrst_i_ready", 32'(i_ready), 32'd0);
      checkOutput("midrst_d_ready", 32'(d_ready), 32'd0);
      tick();
      rst       = 1'b0;
      bus_ready = 1'b0;
      compareAll();
      tick();
      bus_ready = 1'b1;
      bus_rdata = 32'h0BAD_F00D;
      compareAll();
      checkOutput("midrst_regrant", bus_addr, 32'h600);
      checkOutput("midrst_i_ready2", 32'(i_ready), 32'd1);
      tick();
      i_req     = 1'b0;
      bus_ready = 1'b0;
      compareAll();

      // Fetch owner drops its request while BUSY.
      i_req  = 1'b1;
      i_addr = 32'h700;
      compareAll();
      tick();
      i_req = 1'b0;
      compareAll();
      tick();
      bus_ready = 1'b1;
      compareAll();
      checkOutput("drop_i_ready", 32'(i_ready), 32'd0);
      tick();
      bus_ready = 1'b0;
      compareAll();
      checkOutput("drop_idle", 32'(bus_req), 32'd0);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 3000; n++) begin
         tick();
         applyStimulus();
         compareAll();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the core's single memory port between instruction fetch (`if_stage`) and the load/store unit. Sits between the core pipeline and the memory/bus interface. Registers the winning request, holds it on the bus until `bus_ready`, and routes the response back to the owner. A watchdog aborts transactions that never complete.

## Interface
Parameters:
- `TIMEOUT`, 255: bus wait cycles before abort; range 1..65535; counter width is 16 bits.

Ports:
- `clk`  in  1  core clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_req`  in  1  fetch request (`if_stage` `mem_req`).
- `i_addr`  in  `ADDR_W`  fetch address.
- `i_rdata`  out  `XLEN`  fetch read data.
- `i_ready`  out  1  fetch complete, one-cycle pulse.
- `d_req`  in  1  data request.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  `ADDR_W`  data address.
- `d_wdata`  in  `XLEN`  store data.
- `d_wstrb`  in  4  byte enables for stores.
- `d_rdata`  out  `XLEN`  load data.
- `d_ready`  out  1  data complete, one-cycle pulse.
- `bus_req`  out  1  bus request.
- `bus_we`  out  1  bus write enable.
- `bus_addr`  out  `ADDR_W`  bus address.
- `bus_wdata`  out  `XLEN`  bus write data.
- `bus_wstrb`  out  4  bus byte enables.
- `bus_rdata`  in  `XLEN`  bus read data.
- `bus_ready`  in  1  bus completion, one-cycle pulse.
- `bus_err`  out  1  watchdog abort, one-cycle pulse.

## Operation
- States: IDLE, I_BUSY, D_BUSY.
- IDLE: if neither request is asserted, stay. Otherwise pick a winner, latch its `addr`, `we`, `wdata` and `wstrb` into output registers, and go to the winner's BUSY state.
  - Fetch wins: `bus_we` = 0 and `bus_wstrb` = 0.
- BUSY:
  - `bus_req` = 1 and all bus outputs are held constant.
  - On `bus_ready`:
    - Assert the owner's `*_ready` combinationally in the same cycle.
    - Drive the owner's `*_rdata` = `bus_rdata`.
    - Go to IDLE.
- Owner rdata outputs equal `bus_rdata` whenever that owner's ready is high. Otherwise they are 0.
- The non-owner's ready stays 0.
- Arbitration when both request in IDLE: data wins (fixed priority) unless `ARB_RR_EN` is defined.
- Requesters hold `req` and their request fields stable until their ready.
- If the owner drops `req` while BUSY, the transaction still completes and the owner's ready is suppressed.
- Watchdog:
  - Counter `wait_cnt` clears on entry to BUSY and increments each BUSY cycle without `bus_ready`.
  - When `wait_cnt` == `TIMEOUT - 1` and `bus_ready` is still 0:
    - Assert `bus_err`.
    - Assert the owner's ready with rdata = 0.
    - Drop `bus_req` next cycle and go to IDLE.
- `bus_ready` seen in IDLE is ignored.

## Timing
- Reset values: state = IDLE; `wait_cnt` = 0; `bus_req`, `bus_we`, `bus_err`, `i_ready`, `d_ready` = 0; `bus_addr`, `bus_wdata`, `bus_wstrb`, `i_rdata`, `d_rdata` = 0; round-robin pointer = fetch-last (data favoured first).
- Grant latency: request high in IDLE at cycle N gives `bus_req` = 1 at cycle N+1.
- Completion: `bus_ready` at cycle M gives the owner's ready at M. IDLE at M+1, and the next grant is sampled at M+1 with `bus_req` at M+2. This is one bubble cycle between back-to-back transactions.
- Minimum transaction: 2 cycles from request to ready (`bus_ready` in the first BUSY cycle).
- Timeout: with `bus_ready` stuck low, `bus_err` and the owner's ready pulse in the BUSY cycle numbered `TIMEOUT` (1-based).
- Reset asserted mid-transaction: outputs go to their reset values immediately and asynchronously; the in-flight transaction is dropped with no ready pulse.

## Configuration
- `ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit `last_grant` register updates on each grant.
  - On contention, the requester not granted last wins.
- `ARB_RR_EN` undefined: fixed priority, data always wins contention. `last_grant` is not implemented. Sustained data traffic can starve fetch.

## Test plan
- Single fetch: `i_req`=1, `i_addr`=0x100, bus returns 0x00000013 with `bus_ready` in the 1st BUSY cycle -> `bus_req` at cycle 1 with `bus_addr`=0x100 and `bus_we`=0; `i_ready`=1 and `i_rdata`=0x13 at cycle 1.
- Store: `d_req`=1, `d_we`=1, `d_addr`=0x2000, `d_wdata`=0xDEADBEEF, `d_wstrb`=0xF, `bus_ready` after 3 BUSY cycles -> bus fields match and stay stable all 3 cycles; a single `d_ready` pulse; `i_ready` stays 0.
- Contention: `i_req` and `d_req` both held high.
  - Without `ARB_RR_EN` -> the data transaction repeats and fetch is never granted.
  - With `ARB_RR_EN` -> grants alternate D, I, D, I, each separated by one IDLE cycle.
- Timeout: `TIMEOUT`=4, `bus_ready` held 0 -> `bus_err`=1 and `d_ready`=1 with `d_rdata`=0 in the 4th BUSY cycle; `bus_req`=0 and state IDLE next cycle.
- Reset mid-transaction: assert `rst` in the 2nd BUSY cycle -> `bus_req`=0 and both ready outputs = 0 with no clock edge needed; after release, a fresh `i_req` is granted normally.
- Dropped owner request: `i_req` falls during I_BUSY, then `bus_ready`=1 -> `i_ready` stays 0 and the arbiter returns to IDLE.
